// File: rtl/clk_gen_tunable_div.sv
// Glitch-free programmable divider clocked by the raw ring oscillator.
// clk_o has period 2*(D+1) input cycles; divisor changes and stops only land on period boundaries.
module clk_gen_tunable_div #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_DIV = '0
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] div_val_i,
  input  logic             div_load_i,
  output logic             div_ack_o,
  output logic             clk_o,
  output logic             running_o,
  output logic [WIDTH-1:0] div_active_o
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] div_active_q, div_active_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic             clk_q, clk_d;
  logic             ack_q, ack_d;
  logic             running_q, running_d;
  logic             at_top;
  logic             apply;

  assign at_top = (count_q == div_active_q);

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    clk_d        = clk_q;
    div_active_d = div_active_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    apply        = 1'b0;

    unique case (state_q)
      ST_STOP: begin
        count_d = '0;
        clk_d   = 1'b0;
        apply   = pend_valid_q;
        if (en_i) state_d = ST_RUN;
      end
      ST_RUN, ST_DRAIN: begin
        if (at_top) begin
          count_d = '0;
          clk_d   = ~clk_q;
        end else begin
          count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
        // The falling toggle is the only safe moment to swap the divisor.
        apply = at_top && clk_q && (pend_valid_q || div_load_i);
        if (en_i) begin
          state_d = ST_RUN;
        end else if (clk_q) begin
          state_d = at_top ? ST_STOP : ST_DRAIN;
        end else begin
          state_d = ST_STOP;
          count_d = '0;
          clk_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_STOP;
        count_d = '0;
        clk_d   = 1'b0;
      end
    endcase

    if (apply) begin
      div_active_d = div_load_i ? div_val_i : pend_q;
      pend_valid_d = 1'b0;
    end else if (div_load_i) begin
      pend_d       = div_val_i;
      pend_valid_d = 1'b1;
    end

    ack_d     = apply;
    running_d = (state_d != ST_STOP);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_STOP;
      count_q      <= '0;
      clk_q        <= 1'b0;
      div_active_q <= RESET_DIV;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      ack_q        <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      clk_q        <= clk_d;
      div_active_q <= div_active_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      ack_q        <= ack_d;
      running_q    <= running_d;
    end
  end

  assign clk_o        = clk_q;
  assign div_ack_o    = ack_q;
  assign running_o    = running_q;
  assign div_active_o = div_active_q;

endmodule

// File: tb/tb_clk_gen_tunable_div.sv
// Directed bench for clk_gen_tunable_div: cycle-by-cycle vector table plus
// hand-written sequences for the full-range divisor and asynchronous reset.
module tb_clk_gen_tunable_div;

  localparam int WIDTH = 8;

  logic             clk_i = 1'b0;
  logic             reset_n_i;
  logic             en_i;
  logic [WIDTH-1:0] div_val_i;
  logic             div_load_i;
  logic             div_ack_o;
  logic             clk_o;
  logic             running_o;
  logic [WIDTH-1:0] div_active_o;

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic             en;
    logic             load;
    logic [WIDTH-1:0] val;
    logic [15:0]      reps;
    logic             exp_clk;
    logic             exp_run;
    logic             exp_ack;
    logic [WIDTH-1:0] exp_div;
  } vec_t;

  vec_t vecs[$];

  clk_gen_tunable_div #(.WIDTH(WIDTH), .RESET_DIV('0)) dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .en_i        (en_i),
    .div_val_i   (div_val_i),
    .div_load_i  (div_load_i),
    .div_ack_o   (div_ack_o),
    .clk_o       (clk_o),
    .running_o   (running_o),
    .div_active_o(div_active_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic applyStimulus(input logic en, input logic load, input logic [WIDTH-1:0] val);
    en_i       = en;
    div_load_i = load;
    div_val_i  = val;
    @(posedge clk_i);
    #1;
  endtask

  task automatic addVec(input logic en, input logic load, input logic [WIDTH-1:0] val,
                        input int reps, input logic c, input logic r, input logic a,
                        input logic [WIDTH-1:0] d);
    vec_t v;
    v.en = en; v.load = load; v.val = val; v.reps = 16'(reps);
    v.exp_clk = c; v.exp_run = r; v.exp_ack = a; v.exp_div = d;
    vecs.push_back(v);
  endtask

  task automatic checkAll(input string tag, input logic c, input logic r, input logic a,
                          input logic [WIDTH-1:0] d);
    checkOutput({tag, ".clk_o"}, 32'(clk_o), 32'(c));
    checkOutput({tag, ".running_o"}, 32'(running_o), 32'(r));
    checkOutput({tag, ".div_ack_o"}, 32'(div_ack_o), 32'(a));
    checkOutput({tag, ".div_active_o"}, 32'(div_active_o), 32'(d));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    // en, load, val, reps, exp clk, run, ack, div
    // D=0 start, then load 3 while running
    addVec(1, 0, 0, 1, 0, 1, 0, 0);
    addVec(1, 0, 0, 1, 1, 1, 0, 0);
    addVec(1, 0, 0, 1, 0, 1, 0, 0);
    addVec(1, 1, 3, 1, 1, 1, 0, 0);
    addVec(1, 0, 0, 1, 0, 1, 1, 3);
    addVec(1, 0, 0, 3, 0, 1, 0, 3);
    addVec(1, 0, 0, 4, 1, 1, 0, 3);
    // loads 7 then 2 pending, 4 on the apply cycle wins
    addVec(1, 0, 0, 1, 0, 1, 0, 3);
    addVec(1, 1, 7, 1, 0, 1, 0, 3);
    addVec(1, 0, 0, 2, 0, 1, 0, 3);
    addVec(1, 0, 0, 1, 1, 1, 0, 3);
    addVec(1, 1, 2, 1, 1, 1, 0, 3);
    addVec(1, 0, 0, 2, 1, 1, 0, 3);
    addVec(1, 1, 4, 1, 0, 1, 1, 4);
    addVec(1, 0, 0, 4, 0, 1, 0, 4);
    addVec(1, 0, 0, 1, 1, 1, 0, 4);
    addVec(1, 1, 5, 1, 1, 1, 0, 4);
    addVec(1, 0, 0, 3, 1, 1, 0, 4);
    addVec(1, 0, 0, 1, 0, 1, 1, 5);
    // D=5: drop en two cycles into high phase -> drain
    addVec(1, 0, 0, 5, 0, 1, 0, 5);
    addVec(1, 0, 0, 2, 1, 1, 0, 5);
    addVec(0, 0, 0, 4, 1, 1, 0, 5);
    addVec(0, 0, 0, 2, 0, 0, 0, 5);
    // restart, then drop en in low phase
    addVec(1, 0, 0, 6, 0, 1, 0, 5);
    addVec(1, 0, 0, 6, 1, 1, 0, 5);
    addVec(1, 0, 0, 2, 0, 1, 0, 5);
    addVec(0, 0, 0, 2, 0, 0, 0, 5);
    addVec(1, 0, 0, 6, 0, 1, 0, 5);
    // drain then re-enable: high phase stays 6 cycles
    addVec(1, 0, 0, 1, 1, 1, 0, 5);
    addVec(0, 0, 0, 1, 1, 1, 0, 5);
    addVec(1, 0, 0, 4, 1, 1, 0, 5);
    addVec(1, 0, 0, 1, 0, 1, 0, 5);
    addVec(0, 0, 0, 1, 0, 0, 0, 5);
    // load in STOP: ack two cycles after the strobe
    addVec(0, 1, 255, 1, 0, 0, 0, 5);
    addVec(0, 0, 0, 1, 0, 0, 1, 255);
    addVec(0, 0, 0, 1, 0, 0, 0, 255);

    reset_n_i  = 1'b0;
    en_i       = 1'b0;
    div_load_i = 1'b0;
    div_val_i  = '0;
    repeat (3) @(posedge clk_i);
    #1;
    checkAll("in_reset", 0, 0, 0, 0);
    #2 reset_n_i = 1'b1;
    applyStimulus(0, 0, 0);
    checkAll("after_reset", 0, 0, 0, 0);

    foreach (vecs[i]) begin
      for (int r = 0; r < int'(vecs[i].reps); r++) begin
        applyStimulus(vecs[i].en, vecs[i].load && (r == 0), vecs[i].val);
        checkAll($sformatf("vec%0d_%0d", i, r), vecs[i].exp_clk, vecs[i].exp_run,
                 vecs[i].exp_ack, vecs[i].exp_div);
      end
    end

    // D=255: enable and measure first-rise delay and both phases
    applyStimulus(1, 0, 0);
    checkAll("d255_entry", 0, 1, 0, 255);
    n = 0;
    do begin applyStimulus(1, 0, 0); n++; end while (clk_o == 1'b0 && n < 600);
    checkOutput("d255_first_rise", 32'(n), 256);
    n = 0;
    do begin applyStimulus(1, 0, 0); n++; end while (clk_o == 1'b1 && n < 600);
    checkOutput("d255_high_len", 32'(n), 256);
    n = 0;
    do begin applyStimulus(1, 0, 0); n++; end while (clk_o == 1'b0 && n < 600);
    checkOutput("d255_low_len", 32'(n), 256);

    // Mid-high-phase: leave a pending divisor, then hit the async reset
    applyStimulus(1, 1, 9);
    repeat (8) applyStimulus(1, 0, 0);
    checkOutput("pre_reset_clk", 32'(clk_o), 1);
    #2 reset_n_i = 1'b0;
    #1;
    checkAll("async_reset", 0, 0, 0, 0);
    en_i = 1'b0;
    #2 reset_n_i = 1'b1;
    repeat (3) begin
      applyStimulus(0, 0, 0);
      checkAll("post_reset", 0, 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
